// File: rtl/byte_serial_pkg.sv
// Shared definitions for the byte-serial link: FSM states, frame bit levels
// and the default bit period. Imported by both transmitter and receiver.
package byte_serial_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_e;

   localparam logic START_BIT            = 1'b0;
   localparam logic STOP_BIT             = 1'b1;
   localparam int   NUM_DATA_BITS        = 8;
   localparam int   DEFAULT_CLKS_PER_BIT = 4;

endpackage

// File: rtl/byte_serial_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and pulses tick on the last
// cycle of each period. clear holds the count at zero.
module bit_timer #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int              CNT_W   = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // bit-period count register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // tick on the last cycle of a period, then wrap
   always_comb begin
      tick  = 1'b0;
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         tick  = 1'b1;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: rtl/byte_serial_tx.sv
// Byte transmitter: accepts a word on load/ready and sends it as
// start bit, DATA_W data bits LSB-first, stop bit. All outputs registered.
module byte_serial_tx
   import byte_serial_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int DATA_W       = NUM_DATA_BITS
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_in,
   input  logic              load,
   output logic              ready,
   output logic              tx,
   output logic              busy,
   output logic              done
);

   localparam int               IDX_W    = $clog2(DATA_W);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

   state_e             state_q, state_d;
   logic [DATA_W-1:0]  shift_q, shift_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               tx_q, tx_d;
   logic               busy_q, busy_d;
   logic               ready_q, ready_d;
   logic               done_q, done_d;
   logic               tick;
   logic               accept;

   assign accept = load & ready_q;

   bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .clk   (clk),
      .reset (reset),
      .clear (state_q == IDLE),
      .tick  (tick)
   );

   // state, datapath and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         shift_q <= '0;
         idx_q   <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
         done_q  <= done_d;
      end
   end

   // next state, shift register and bit index; everything advances on tick
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      idx_d   = idx_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = START;
               shift_d = data_in;
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            if (tick) begin
               state_d = DATA;
               idx_d   = '0;
            end else begin
               state_d = START;
            end
         end
         DATA: begin
            if (tick) begin
               shift_d = {1'b0, shift_q[DATA_W-1:1]};
               if (idx_q == LAST_IDX) begin
                  state_d = STOP;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else begin
               state_d = DATA;
            end
         end
         STOP: begin
            if (tick) begin
               state_d = IDLE;
            end else begin
               state_d = STOP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // outputs derived from the upcoming state so they land registered in step with it
   always_comb begin
      tx_d    = STOP_BIT;
      busy_d  = 1'b0;
      ready_d = 1'b0;
      done_d  = 1'b0;
      case (state_d)
         IDLE: begin
            ready_d = 1'b1;
            done_d  = (state_q == STOP);
         end
         START: begin
            tx_d   = START_BIT;
            busy_d = 1'b1;
         end
         DATA: begin
            tx_d   = shift_d[0];
            busy_d = 1'b1;
         end
         STOP: begin
            tx_d   = STOP_BIT;
            busy_d = 1'b1;
         end
         default: begin
            tx_d = STOP_BIT;
         end
      endcase
   end

   assign tx    = tx_q;
   assign busy  = busy_q;
   assign ready = ready_q;
   assign done  = done_q;

endmodule

// File: tb/tb_byte_serial_tx.sv
// Self-checking bench for byte_serial_tx: a frame-timeline model checked every
// cycle on three instances (CLKS_PER_BIT 4, 2, 7) plus hand-computed literals.
module tb_byte_serial_tx;

   localparam int CPB [3] = '{4, 2, 7};

   logic       clk = 1'b0;
   logic       rst     [3];
   logic       load    [3];
   logic [7:0] din     [3];
   logic       tx_w    [3];
   logic       busy_w  [3];
   logic       ready_w [3];
   logic       done_w  [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   byte_serial_tx #(.CLKS_PER_BIT(4)) u_dut4 (
      .clk(clk), .reset(rst[0]), .data_in(din[0]), .load(load[0]),
      .ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]));
   byte_serial_tx #(.CLKS_PER_BIT(2)) u_dut2 (
      .clk(clk), .reset(rst[1]), .data_in(din[1]), .load(load[1]),
      .ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]));
   byte_serial_tx #(.CLKS_PER_BIT(7)) u_dut7 (
      .clk(clk), .reset(rst[2]), .data_in(din[2]), .load(load[2]),
      .ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]));

   task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s t=%0t got %0h want %0h", nm, $time, got, want);
      end
   endtask

   // Expected {tx,busy,ready,done} in the k-th cycle after a handshake edge.
   function automatic logic [3:0] exp_out(bit a, int k, logic [7:0] by, int c);
      int  bi;
      logic t;
      if (!a || k < 1 || k > 10 * c + 1) return 4'b1010;
      if (k == 10 * c + 1) return 4'b1011;
      bi = (k - 1) / c;
      if (bi == 0)      t = 1'b0;
      else if (bi == 9) t = 1'b1;
      else              t = by[bi - 1];
      return {t, 3'b100};
   endfunction

   int         cyc = 0;
   bit         act [3];
   int         t0  [3];
   logic [7:0] mb  [3];
   logic [3:0] e_m;
   logic [3:0] e_c;

   // model: cyc indexes the cycle ending at this edge
   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         e_m = exp_out(act[i], cyc - t0[i], mb[i], CPB[i]);
         if (rst[i]) begin
            act[i] <= 1'b0;
         end else if (load[i] && e_m[1]) begin
            act[i] <= 1'b1;
            t0[i]  <= cyc;
            mb[i]  <= din[i];
         end
      end
      cyc <= cyc + 1;
   end

   always @(posedge clk) begin
      #1;
      for (int i = 0; i < 3; i++) begin
         e_c = exp_out(act[i], cyc - t0[i], mb[i], CPB[i]);
         chk($sformatf("model_inst%0d", i),
             {28'd0, tx_w[i], busy_w[i], ready_w[i], done_w[i]}, {28'd0, e_c});
      end
   end

   // Runs one frame on instance i and checks it against literal frame bits.
   task automatic frame_lit(int i, logic [7:0] d, logic [9:0] bits, bit pre,
                            bit hold, logic [7:0] d2, bit inj);
      int c;
      int nb;
      int nd;
      c  = CPB[i];
      nb = 0;
      nd = 0;
      if (!pre) begin
         @(negedge clk);
         din[i]  = d;
         load[i] = 1'b1;
      end
      @(posedge clk);
      for (int n = 1; n <= 10 * c + 1; n++) begin
         @(negedge clk);
         if (n == 1) begin
            chk("start_edge", tx_w[i], 1'b0);
            if (hold) din[i] = d2;
            else      load[i] = 1'b0;
         end
         if (inj && n == 15) begin
            din[i]  = 8'hFF;
            load[i] = 1'b1;
         end
         if (inj && n == 17) load[i] = 1'b0;
         if (n <= 10 * c) begin
            if ((n - 1) % c == c / 2) chk("mid_bit", tx_w[i], bits[(n - 1) / c]);
            if (busy_w[i]) nb++;
            if (done_w[i]) nd++;
         end else begin
            chk("done_pulse", done_w[i], 1'b1);
            chk("ready_done", ready_w[i], 1'b1);
            chk("busy_done", busy_w[i], 1'b0);
         end
      end
      chk("busy_len", nb, 10 * c);
      chk("early_done", nd, 0);
   endtask

   initial begin
      int nb;
      for (int i = 0; i < 3; i++) begin
         rst[i]  = 1'b1;
         load[i] = 1'b0;
         din[i]  = 8'h00;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) rst[i] = 1'b0;
      repeat (2) @(negedge clk);

      // reset while idle, held 3 cycles, then quiet afterwards
      rst[0] = 1'b1;
      for (int n = 0; n < 6; n++) begin
         if (n == 3) rst[0] = 1'b0;
         #1;
         chk("rst_tx", tx_w[0], 1'b1);
         chk("rst_ready", ready_w[0], 1'b1);
         chk("rst_busy", busy_w[0], 1'b0);
         chk("rst_done", done_w[0], 1'b0);
         @(negedge clk);
      end

      // single frame of A5: 0,1,0,1,0,0,1,0,1,1
      frame_lit(0, 8'hA5, 10'b1101001010, 1'b0, 1'b0, 8'h00, 1'b0);
      repeat (2) @(negedge clk);

      // frame of 00 with an FF load while busy that must be ignored
      frame_lit(0, 8'h00, 10'b1000000000, 1'b0, 1'b0, 8'h00, 1'b1);
      nb = 0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (busy_w[0]) nb++;
      end
      chk("no_second_frame", nb, 0);

      // back-to-back 3C then C3 accepted in the done cycle
      frame_lit(0, 8'h3C, 10'b1001111000, 1'b0, 1'b1, 8'hC3, 1'b0);
      frame_lit(0, 8'hC3, 10'b1110000110, 1'b1, 1'b0, 8'h00, 1'b0);
      repeat (3) @(negedge clk);

      // reset during data bit 4 of 5A
      din[0]  = 8'h5A;
      load[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      load[0] = 1'b0;
      repeat (21) @(negedge clk);
      chk("pre_rst_busy", busy_w[0], 1'b1);
      rst[0] = 1'b1;
      #1;
      chk("async_tx", tx_w[0], 1'b1);
      chk("async_busy", busy_w[0], 1'b0);
      chk("async_ready", ready_w[0], 1'b1);
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         chk("rst_no_done", done_w[0], 1'b0);
      end
      rst[0] = 1'b0;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         chk("post_rst_done", done_w[0], 1'b0);
      end
      frame_lit(0, 8'h81, 10'b1100000010, 1'b0, 1'b0, 8'h00, 1'b0);

      // parameter sweep with 01
      frame_lit(1, 8'h01, 10'b1000000010, 1'b0, 1'b0, 8'h00, 1'b0);
      frame_lit(2, 8'h01, 10'b1000000010, 1'b0, 1'b0, 8'h00, 1'b0);
      repeat (4) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
